// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, in_op field positions,
// FSM state type and the size-to-byte-count helper.
package mem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   // in_op = {load, store, size[1:0], uns}
   localparam int OP_LOAD     = 4;
   localparam int OP_STORE    = 3;
   localparam int OP_SIZE_LSB = 1;
   localparam int OP_UNS      = 0;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   function automatic logic [3:0] bytes_of(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and lane-shifted write data, and
// extraction plus sign/zero extension of load data, all from {size, uns, off}.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int NB     = DATA_W / 8,
   localparam int OFF_W  = $clog2(NB)
) (
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [OFF_W-1:0]  off,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [NB-1:0]     be,
   output logic [DATA_W-1:0] wdata_sh,
   output logic [DATA_W-1:0] rdata_ext
);

   logic [3:0]        nbytes;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] field;
   logic              sign;

   always_comb begin
      nbytes = bytes_of(size);
      if (nbytes > 4'(NB)) nbytes = 4'(NB);
      mask = '0;
      be   = '0;
      for (int i = 0; i < NB; i++) begin
         mask[8*i +: 8] = {8{4'(i) < nbytes}};
         be[i]          = 4'(i) < nbytes;
      end
      be       = be << off;
      wdata_sh = (wdata & mask) << {off, 3'b000};
      field    = (rdata >> {off, 3'b000}) & mask;
      // mask is contiguous from bit 0, so its top set bit marks the field's sign bit
      sign      = |(field & mask & ~(mask >> 1));
      rdata_ext = (uns || !sign) ? field : (field | ~mask);
   end

endmodule

// File: rtl/mem_access_unit.sv
// EXE->WB memory-access stage: request/grant/response data port, lane steering,
// and result hold until WB accepts. Alignment exceptions enabled by MEM_ALIGN_EXC_EN.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   parameter  int RD_W   = 5,
   localparam int NB     = DATA_W / 8,
   localparam int OFF_W  = $clog2(NB)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_op,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic              in_rf_wen,
   input  logic [RD_W-1:0]   in_rd,
   input  logic [31:0]       in_pc,
   output logic              dm_req,
   output logic              dm_we,
   output logic [NB-1:0]     dm_be,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_gnt,
   input  logic              dm_rvalid,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_rf_wen,
   output logic [RD_W-1:0]   out_rd,
   output logic [31:0]       out_pc,
   output logic              out_exc,
   output logic [ADDR_W-1:0] out_badvaddr,
   output logic [RD_W-1:0]   fwd_wdest,
   output state_t            dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; the
   // producer holds its payload stable while valid is high and ready is low.

   state_t state_q, state_d;

   logic              load_q, uns_q, rf_wen_q, exc_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, result_q;
   logic [RD_W-1:0]   rd_q;
   logic [31:0]       pc_q;

   logic              accept, is_load, is_mem, misal;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr_al;
   logic [NB-1:0]     be;
   logic [DATA_W-1:0] wdata_sh, rdata_ext;

   assign accept  = in_valid && (state_q == S_IDLE);
   assign is_load = in_op[OP_LOAD];
   assign is_mem  = in_op[OP_LOAD] || in_op[OP_STORE];
   assign size    = in_op[OP_SIZE_LSB +: 2];

`ifdef MEM_ALIGN_EXC_EN
   assign misal   = is_mem && ((|(in_addr[2:0] & 3'(bytes_of(size) - 4'd1)))
                               || (bytes_of(size) > 4'(NB)));
   assign addr_al = in_addr;
`else
   logic [3:0] nbytes;
   // Without exceptions the access is forced aligned to its (bus-clamped) size
   assign nbytes  = (bytes_of(size) > 4'(NB)) ? 4'(NB) : bytes_of(size);
   assign misal   = 1'b0;
   assign addr_al = is_mem ? (in_addr & ~ADDR_W'(nbytes - 4'd1)) : in_addr;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_be    = '0;
      dm_addr  = '0;
      dm_wdata = '0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (accept) state_d = (is_mem && !misal) ? S_REQ : S_DONE;
         end
         S_REQ: begin
            dm_req   = 1'b1;
            dm_we    = !load_q;
            dm_be    = be;
            dm_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            dm_wdata = load_q ? '0 : wdata_sh;
            if (dm_gnt) state_d = load_q ? S_WAIT : S_DONE;
         end
         S_WAIT: if (dm_rvalid) state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_q   <= 1'b0;
         uns_q    <= 1'b0;
         rf_wen_q <= 1'b0;
         exc_q    <= 1'b0;
         size_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         result_q <= '0;
         rd_q     <= '0;
         pc_q     <= '0;
      end else if (accept) begin
         load_q   <= is_load;
         uns_q    <= in_op[OP_UNS];
         rf_wen_q <= in_rf_wen;
         exc_q    <= misal;
         size_q   <= size;
         addr_q   <= addr_al;
         wdata_q  <= in_wdata;
         result_q <= DATA_W'(in_addr);
         rd_q     <= in_rd;
         pc_q     <= in_pc;
      end else if (state_q == S_WAIT && dm_rvalid) begin
         result_q <= rdata_ext;
      end
   end

   mem_lane_align #(.DATA_W(DATA_W)) u_lane (
      .size      (size_q),
      .uns       (uns_q),
      .off       (addr_q[OFF_W-1:0]),
      .wdata     (wdata_q),
      .rdata     (dm_rdata),
      .be        (be),
      .wdata_sh  (wdata_sh),
      .rdata_ext (rdata_ext)
   );

   assign out_valid  = (state_q == S_DONE);
   assign out_result = result_q;
   assign out_rf_wen = out_valid && rf_wen_q && !exc_q;
   assign out_rd     = rd_q;
   assign out_pc     = pc_q;
   assign fwd_wdest  = (state_q != S_IDLE && rf_wen_q) ? rd_q : '0;
   assign dbg_state  = state_q;

`ifdef MEM_ALIGN_EXC_EN
   assign out_exc      = out_valid && exc_q;
   assign out_badvaddr = exc_q ? addr_q : '0;
`else
   assign out_exc      = 1'b0;
   assign out_badvaddr = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit and a 64-bit instance share stimulus, with
// directed vectors, reset-abort sequences and randomized accesses against a byte model.
`timescale 1ns/1ps
module tb_mem_access_unit;
   import mem_pkg::*;

   typedef struct {
      bit          w64;
      logic [4:0]  op;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      bit          rf_wen;
      logic [4:0]  rd;
      logic [31:0] pc;
      int          gdly;
      int          rdly;
      int          hold;
      bit          mem;
      bit          load;
      bit          exc;
      logic [7:0]  be;
      logic [63:0] dwdata;
      logic [31:0] daddr;
      logic [63:0] result;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, sel64, drv_valid, drv_gnt, drv_rvalid, in_rf_wen, out_ready;
   logic [4:0]  in_op, in_rd;
   logic [31:0] in_addr, in_pc;
   logic [63:0] in_wdata, dm_rdata;

   logic        in_ready_a, dm_req_a, dm_we_a, out_valid_a, out_rf_wen_a, out_exc_a;
   logic [3:0]  dm_be_a;
   logic [31:0] dm_addr_a, dm_wdata_a, out_result_a, out_pc_a, out_badvaddr_a;
   logic [4:0]  out_rd_a, fwd_a;
   state_t      st_a;

   logic        in_ready_b, dm_req_b, dm_we_b, out_valid_b, out_rf_wen_b, out_exc_b;
   logic [7:0]  dm_be_b;
   logic [31:0] dm_addr_b, out_pc_b, out_badvaddr_b;
   logic [63:0] dm_wdata_b, out_result_b;
   logic [4:0]  out_rd_b, fwd_b;
   state_t      st_b;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32), .RD_W(5)) dut_a (
      .clk(clk), .rst(rst), .in_valid(drv_valid & ~sel64), .in_ready(in_ready_a),
      .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata[31:0]), .in_rf_wen(in_rf_wen),
      .in_rd(in_rd), .in_pc(in_pc), .dm_req(dm_req_a), .dm_we(dm_we_a), .dm_be(dm_be_a),
      .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a), .dm_gnt(drv_gnt & ~sel64),
      .dm_rvalid(drv_rvalid & ~sel64), .dm_rdata(dm_rdata[31:0]), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_result(out_result_a), .out_rf_wen(out_rf_wen_a),
      .out_rd(out_rd_a), .out_pc(out_pc_a), .out_exc(out_exc_a),
      .out_badvaddr(out_badvaddr_a), .fwd_wdest(fwd_a), .dbg_state(st_a)
   );

   mem_access_unit #(.ADDR_W(32), .DATA_W(64), .RD_W(5)) dut_b (
      .clk(clk), .rst(rst), .in_valid(drv_valid & sel64), .in_ready(in_ready_b),
      .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_rf_wen(in_rf_wen),
      .in_rd(in_rd), .in_pc(in_pc), .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_be(dm_be_b),
      .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b), .dm_gnt(drv_gnt & sel64),
      .dm_rvalid(drv_rvalid & sel64), .dm_rdata(dm_rdata), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_result(out_result_b), .out_rf_wen(out_rf_wen_b),
      .out_rd(out_rd_b), .out_pc(out_pc_b), .out_exc(out_exc_b),
      .out_badvaddr(out_badvaddr_b), .fwd_wdest(fwd_b), .dbg_state(st_b)
   );

   logic        s_in_ready, s_req, s_we, s_valid, s_rf_wen, s_exc;
   logic [7:0]  s_be;
   logic [31:0] s_daddr, s_pc, s_badv;
   logic [63:0] s_dwdata, s_result;
   logic [4:0]  s_rd, s_fwd;

   assign s_in_ready = sel64 ? in_ready_b     : in_ready_a;
   assign s_req      = sel64 ? dm_req_b       : dm_req_a;
   assign s_we       = sel64 ? dm_we_b        : dm_we_a;
   assign s_be       = sel64 ? dm_be_b        : {4'b0, dm_be_a};
   assign s_daddr    = sel64 ? dm_addr_b      : dm_addr_a;
   assign s_dwdata   = sel64 ? dm_wdata_b     : {32'b0, dm_wdata_a};
   assign s_valid    = sel64 ? out_valid_b    : out_valid_a;
   assign s_result   = sel64 ? out_result_b   : {32'b0, out_result_a};
   assign s_rf_wen   = sel64 ? out_rf_wen_b   : out_rf_wen_a;
   assign s_rd       = sel64 ? out_rd_b       : out_rd_a;
   assign s_pc       = sel64 ? out_pc_b       : out_pc_a;
   assign s_exc      = sel64 ? out_exc_b      : out_exc_a;
   assign s_badv     = sel64 ? out_badvaddr_b : out_badvaddr_a;
   assign s_fwd      = sel64 ? fwd_b          : fwd_a;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: walks the access byte by byte over the bus lanes.
   function automatic vec_t model(input bit w64, input logic [4:0] op, input logic [31:0] addr,
                                  input logic [63:0] wdata, input logic [63:0] rdata);
      vec_t        v;
      int          nb, n, off;
      logic [31:0] a;
      logic [63:0] r;
      v = '{default: '0};
      v.w64 = w64; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      nb     = w64 ? 8 : 4;
      n      = 1 << op[2:1];
      v.load = op[4];
      v.mem  = op[4] || op[3];
      if (!v.mem) begin
         v.result = {32'b0, addr};
         return v;
      end
`ifdef MEM_ALIGN_EXC_EN
      if ((addr % n) != 0 || n > nb) begin
         v.exc = 1'b1;
         return v;
      end
      a = addr;
`else
      if (n > nb) n = nb;
      a = addr - (addr % n);
`endif
      off     = int'(a % nb);
      v.daddr = a - (a % nb);
      r       = '0;
      for (int i = 0; i < n; i++) begin
         v.be[off+i]                = 1'b1;
         v.dwdata[8*(off+i) +: 8]   = wdata[8*i +: 8];
         r[8*i +: 8]                = rdata[8*(off+i) +: 8];
      end
      if (!op[0] && n < 8 && r[8*n-1]) r = r | (~64'h0 << (8*n));
      if (!w64) r = r & 64'hFFFF_FFFF;
      v.result = r;
      return v;
   endfunction

   function automatic vec_t tv(input bit w64, input logic [4:0] op, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [63:0] rdata, input bit rf_wen,
                               input int gdly, input int rdly, input int hold, input bit exc,
                               input logic [7:0] be, input logic [63:0] dwdata,
                               input logic [31:0] daddr, input logic [63:0] result);
      vec_t v;
      v = '{default: '0};
      v.w64 = w64; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.rf_wen = rf_wen; v.gdly = gdly; v.rdly = rdly; v.hold = hold;
      v.mem = op[4] || op[3]; v.load = op[4]; v.exc = exc;
      v.be = be; v.dwdata = dwdata; v.daddr = daddr; v.result = result;
      return v;
   endfunction

   // Called at a falling edge; returns at a falling edge with the unit back in IDLE.
   task automatic run_txn(input vec_t v, input string tag);
      int          lat;
      logic [4:0]  efwd;
      efwd  = v.rf_wen ? v.rd : 5'd0;
      sel64 = v.w64;
      out_ready = 1'b0; drv_gnt = 1'b0; drv_rvalid = 1'b0;
      #1;
      chk({tag, ".in_ready_idle"}, s_in_ready, 1);
      in_op = v.op; in_addr = v.addr; in_wdata = v.wdata; in_rf_wen = v.rf_wen;
      in_rd = v.rd; in_pc = v.pc; drv_valid = 1'b1;
      @(negedge clk);
      drv_valid = 1'b0;
      in_op = 5'($urandom); in_addr = $urandom; in_wdata = {$urandom, $urandom};
      lat = 1;
      if (v.mem && !v.exc) begin
         for (int g = 0; g <= v.gdly; g++) begin
            chk($sformatf("%s.req_c%0d", tag, g), s_req, 1);
            chk({tag, ".we"}, s_we, !v.load);
            chk({tag, ".be"}, s_be, v.be);
            chk({tag, ".dm_addr"}, s_daddr, v.daddr);
            if (!v.load) chk({tag, ".dm_wdata"}, s_dwdata, v.dwdata);
            chk({tag, ".busy_in_ready"}, s_in_ready, 0);
            chk({tag, ".fwd_req"}, s_fwd, efwd);
            drv_gnt    = (g == v.gdly);
            drv_rvalid = v.load && ($urandom_range(0, 1) == 1);
            dm_rdata   = {$urandom, $urandom};
            @(negedge clk);
            drv_gnt = 1'b0; drv_rvalid = 1'b0;
            lat++;
         end
         if (v.load) begin
            for (int r = 0; r <= v.rdly; r++) begin
               chk($sformatf("%s.wait_c%0d", tag, r), {s_req, s_valid}, 2'b00);
               drv_rvalid = (r == v.rdly);
               dm_rdata   = (r == v.rdly) ? v.rdata : {$urandom, $urandom};
               @(negedge clk);
               drv_rvalid = 1'b0;
               lat++;
            end
         end
      end else begin
         chk({tag, ".no_req"}, s_req, 0);
      end
      for (int h = 0; h <= v.hold; h++) begin
         chk($sformatf("%s.valid_lat%0d", tag, lat), s_valid, 1);
         if (!v.exc && (v.load || !v.mem)) chk({tag, ".result"}, s_result, v.result);
         chk({tag, ".exc"}, s_exc, v.exc);
         chk({tag, ".badvaddr"}, s_badv, v.exc ? v.addr : 32'h0);
         chk({tag, ".rf_wen"}, s_rf_wen, v.rf_wen && !v.exc);
         chk({tag, ".rd"}, s_rd, v.rd);
         chk({tag, ".pc"}, s_pc, v.pc);
         chk({tag, ".done_in_ready"}, s_in_ready, 0);
         chk({tag, ".done_req"}, s_req, 0);
         chk({tag, ".fwd_done"}, s_fwd, efwd);
         out_ready  = (h == v.hold);
         drv_rvalid = ($urandom_range(0, 1) == 1);
         dm_rdata   = {$urandom, $urandom};
         @(negedge clk);
         out_ready = 1'b0; drv_rvalid = 1'b0;
      end
      chk({tag, ".after_valid"}, s_valid, 0);
      chk({tag, ".after_in_ready"}, s_in_ready, 1);
      chk({tag, ".after_fwd"}, s_fwd, 0);
   endtask

   task automatic start_load(input logic [31:0] addr, input logic [4:0] rd);
      sel64 = 1'b0;
      in_op = 5'b10100; in_addr = addr; in_wdata = '0; in_rf_wen = 1'b1; in_rd = rd;
      in_pc = 32'h900; drv_valid = 1'b1;
      @(negedge clk);
      drv_valid = 1'b0;
   endtask

   vec_t tab[12];
   vec_t rv;

   initial begin
      rst = 1'b1; sel64 = 1'b0; drv_valid = 1'b0; drv_gnt = 1'b0; drv_rvalid = 1'b0;
      in_op = '0; in_addr = '0; in_wdata = '0; in_rf_wen = 1'b0; in_rd = '0; in_pc = '0;
      dm_rdata = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst.in_ready_a", in_ready_a, 1);
      chk("rst.in_ready_b", in_ready_b, 1);
      chk("rst.dm_a", {dm_req_a, dm_we_a, dm_be_a, dm_addr_a, dm_wdata_a}, 0);
      chk("rst.dm_b", {dm_req_b, dm_we_b, dm_be_b, dm_addr_b}, 0);
      chk("rst.dm_wdata_b", dm_wdata_b, 0);
      chk("rst.out_a", {out_valid_a, out_exc_a, out_rf_wen_a, out_rd_a, out_pc_a}, 0);
      chk("rst.out_data_a", {out_result_a, out_badvaddr_a, fwd_a}, 0);
      chk("rst.out_b", {out_valid_b, out_exc_b, out_rf_wen_b, out_rd_b, out_pc_b, fwd_b}, 0);
      chk("rst.out_result_b", out_result_b, 0);
      chk("rst.state_a", st_a, S_IDLE);
      rst = 1'b0;
      @(negedge clk);

      tab[0]  = tv(0, 5'b01000, 32'h1003, 64'hFFFF_FFAB, 0, 0, 0, 0, 0, 0,
                   8'h08, 64'hAB00_0000, 32'h1000, 0);
      tab[1]  = tv(0, 5'b10010, 32'h2002, 0, 64'h80FF_1234, 1, 2, 2, 0, 0,
                   8'h0C, 0, 32'h2000, 64'hFFFF_80FF);
      tab[2]  = tv(0, 5'b10011, 32'h2002, 0, 64'h80FF_1234, 1, 2, 2, 0, 0,
                   8'h0C, 0, 32'h2000, 64'h0000_80FF);
`ifdef MEM_ALIGN_EXC_EN
      tab[3]  = tv(0, 5'b10100, 32'h3001, 0, 64'hDEAD_BEEF, 1, 0, 0, 0, 1,
                   0, 0, 0, 0);
`else
      tab[3]  = tv(0, 5'b10100, 32'h3001, 0, 64'hDEAD_BEEF, 1, 1, 1, 0, 0,
                   8'h0F, 0, 32'h3000, 64'hDEAD_BEEF);
`endif
      tab[4]  = tv(1, 5'b10110, 32'h8, 0, 64'h8877_6655_4433_2211, 1, 0, 0, 1, 0,
                   8'hFF, 0, 32'h8, 64'h8877_6655_4433_2211);
      tab[5]  = tv(1, 5'b10000, 32'hF, 0, 64'h7F00_0000_0000_0000, 1, 1, 0, 0, 0,
                   8'h80, 0, 32'h8, 64'h7F);
      tab[6]  = tv(0, 5'b00000, 32'h1234_5678, 0, 0, 1, 0, 0, 4, 0,
                   0, 0, 0, 64'h1234_5678);
      tab[7]  = tv(0, 5'b11100, 32'h40, 64'hFFFF_FFFF, 64'h0102_0304, 1, 0, 0, 0, 0,
                   8'h0F, 0, 32'h40, 64'h0102_0304);
      tab[8]  = tv(1, 5'b01110, 32'h10, 64'h1122_3344_5566_7788, 0, 0, 1, 0, 0, 0,
                   8'hFF, 64'h1122_3344_5566_7788, 32'h10, 0);
      tab[9]  = tv(1, 5'b01100, 32'h14, 64'hFFFF_FFFF_CAFE_BABE, 0, 0, 0, 0, 0, 0,
                   8'hF0, 64'hCAFE_BABE_0000_0000, 32'h10, 0);
      tab[10] = tv(0, 5'b10000, 32'h2001, 0, 64'h0000_8000, 1, 0, 1, 0, 0,
                   8'h02, 0, 32'h2000, 64'hFFFF_FF80);
      tab[11] = tv(0, 5'b01010, 32'h2006, 64'h1234_BEEF, 0, 0, 3, 0, 1, 0,
                   8'h0C, 64'hBEEF_0000, 32'h2004, 0);

      for (int i = 0; i < 12; i++) begin
         tab[i].rd = 5'(i + 1);
         tab[i].pc = 32'h100 + 32'(i * 4);
         run_txn(tab[i], $sformatf("t%0d", i));
      end

      // reset while waiting for read data: request dropped, late rvalid ignored
      start_load(32'h50, 5'd9);
      chk("rw.req", dm_req_a, 1);
      drv_gnt = 1'b1;
      @(negedge clk);
      drv_gnt = 1'b0;
      chk("rw.wait_fwd", fwd_a, 9);
      rst = 1'b1;
      #1;
      chk("rw.rst_outs", {dm_req_a, out_valid_a, fwd_a}, 0);
      chk("rw.rst_in_ready", in_ready_a, 1);
      @(negedge clk);
      rst = 1'b0; drv_rvalid = 1'b1; dm_rdata = 64'h5555_AAAA;
      @(negedge clk);
      drv_rvalid = 1'b0;
      chk("rw.late_rvalid", {out_valid_a, dm_req_a}, 0);
      chk("rw.late_in_ready", in_ready_a, 1);

      // reset while requesting
      start_load(32'h60, 5'd10);
      chk("rr.req", dm_req_a, 1);
      rst = 1'b1;
      #1;
      chk("rr.rst_req", {dm_req_a, dm_be_a, dm_addr_a}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rv = model(0, 5'b10101, 32'h62, 0, 64'hA5B6_C7D8);
      rv.rf_wen = 1; rv.rd = 5'd11; rv.pc = 32'h904; rv.gdly = 1; rv.rdly = 0;
      run_txn(rv, "rr.next");

      for (int i = 0; i < 60; i++) begin
         bit          w64, ld, st;
         int          k;
         logic [1:0]  sz;
         logic [31:0] addr;
         w64 = ($urandom_range(0, 1) == 1);
         k   = $urandom_range(0, 9);
         ld  = (k >= 2 && k <= 5) || k == 9;
         st  = (k >= 6);
         sz  = 2'($urandom_range(0, 3));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
         rv = model(w64, {ld, st, sz, 1'($urandom_range(0, 1))}, addr,
                    {$urandom, $urandom}, {$urandom, $urandom});
         rv.rf_wen = ($urandom_range(0, 1) == 1);
         rv.rd     = 5'($urandom);
         rv.pc     = $urandom;
         rv.gdly   = $urandom_range(0, 3);
         rv.rdly   = $urandom_range(0, 3);
         rv.hold   = $urandom_range(0, 2);
         run_txn(rv, $sformatf("r%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
